// File: rtl/spin_line_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : spin_line_scheduler                                          |
// | Description : Hall-index locked frame/line strobe generator for the        |
// |               TLC5957 line driver. Optional macro SPIN_SCHED_AVG_EN        |
// |               averages the last two accepted gaps before slotting.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module spin_line_scheduler #(
  parameter int LINES       = 128,
  parameter int LINES_BITS  = 7,
  parameter int PERIOD_BITS = 24,
  parameter int MIN_PERIOD  = 131072
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   hall,
  output logic                   frame_pulse,
  output logic                   line_pulse,
  output logic [LINES_BITS-1:0]  line_index,
  output logic                   locked,
  output logic [PERIOD_BITS-1:0] period
);

  localparam logic [PERIOD_BITS-1:0] c_max_period = '1;
  localparam logic [PERIOD_BITS-1:0] c_one        = PERIOD_BITS'(1);
  localparam logic [PERIOD_BITS:0]   c_min_period = (PERIOD_BITS+1)'(MIN_PERIOD);
  localparam logic [LINES_BITS-1:0]  c_last_line  = LINES_BITS'(LINES-1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_start;
  logic [2:0]             r_sync;
  logic                   w_idx;
  logic [PERIOD_BITS-1:0] r_cnt;
  logic [PERIOD_BITS-1:0] r_interval;
  logic [PERIOD_BITS-1:0] r_timer;
  logic [LINES_BITS-1:0]  r_line_next;
  logic                   r_active;
  logic [PERIOD_BITS:0]   w_gap_full;
  logic [PERIOD_BITS-1:0] w_gap;
  logic [PERIOD_BITS-1:0] w_period_p;
  logic                   w_accept;
  logic                   w_stall;

  // r_sync[1:0] is the synchronizer, r_sync[2] the edge-detect history
  assign w_idx      = r_sync[1] & ~r_sync[2];
  assign w_gap_full = {1'b0, r_cnt} + (PERIOD_BITS+1)'(1);
  assign w_gap      = (r_cnt == c_max_period) ? c_max_period : r_cnt + c_one;
  assign w_accept   = w_idx && (w_gap_full >= c_min_period);
  assign w_stall    = (r_cnt == c_max_period);
  assign locked     = (r_state == ST_RUN);

`ifdef SPIN_SCHED_AVG_EN
  logic [PERIOD_BITS-1:0] r_prev_gap;
  logic [PERIOD_BITS-1:0] w_prev_sel;
  logic [PERIOD_BITS:0]   w_sum;

  // On the first lock there is no history, so the current gap stands in
  assign w_prev_sel = (r_state == ST_RUN) ? r_prev_gap : w_gap;
  assign w_sum      = {1'b0, w_prev_sel} + {1'b0, w_gap};
  assign w_period_p = PERIOD_BITS'(w_sum >> 1);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gap <= '0;
    end else if (w_start) begin
      r_prev_gap <= w_gap;
    end
  end
`else
  assign w_period_p = w_gap;
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_next = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (w_accept) w_state_next = ST_MEASURE;
      end
      ST_MEASURE, ST_RUN: begin
        if (w_stall) begin
          w_state_next = ST_ACQUIRE;
        end else if (w_accept) begin
          w_state_next = ST_RUN;
          w_start      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (!enable) begin
      w_state_next = ST_IDLE;
      w_start      = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_cnt       <= '0;
      r_interval  <= '0;
      r_timer     <= '0;
      r_line_next <= '0;
      r_active    <= 1'b0;
      frame_pulse <= 1'b0;
      line_pulse  <= 1'b0;
      line_index  <= '0;
      period      <= '0;
    end else begin
      r_sync      <= {r_sync[1:0], hall};
      frame_pulse <= w_start;
      line_pulse  <= 1'b0;
      if (w_accept) begin
        r_cnt <= '0;
      end else if (!w_stall) begin
        r_cnt <= r_cnt + c_one;
      end
      // An index always restarts the revolution, pre-empting any pending line
      if (w_start) begin
        period      <= w_period_p;
        r_interval  <= w_period_p >> LINES_BITS;
        r_timer     <= '0;
        r_line_next <= '0;
        r_active    <= 1'b1;
      end else if (r_active && (r_state == ST_RUN) && (w_state_next == ST_RUN)) begin
        if (r_timer == '0) begin
          line_pulse  <= 1'b1;
          line_index  <= r_line_next;
          r_line_next <= r_line_next + LINES_BITS'(1);
          r_timer     <= (r_interval == '0) ? '0 : r_interval - c_one;
          if (r_line_next == c_last_line) r_active <= 1'b0;
        end else begin
          r_timer <= r_timer - c_one;
        end
      end else if (w_state_next != ST_RUN) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
